qa7_tty_seg: RTL and testbench
==============================

Name: qa7_tty_seg

Overview:
- Debug display stage between the CPU wrapper's tty debug stream (tty_stb/tty_dat/tty_end) and the board's three-digit seven-segment multiplexer (seg_hex0..2).
- Buffers debug bytes in a small FIFO and shows each byte in hex for at least HOLD_MS milliseconds, so fast output remains readable.
- Digit 2 shows a mod-16 count of displayed bytes.
- Freezes the display on tty_end.

Parameters:
- DEPTH, 8, FIFO depth in bytes; power of 2, 2..64.
- HOLD_MS, 250, minimum display time per byte in ena_ms ticks; 0 means no hold.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active high.
- ena_ms  in  1  single-clock millisecond strobe.
- tty_stb  in  1  single-clock strobe; tty_dat is valid in that cycle.
- tty_dat  in  8  debug byte.
- tty_end  in  1  single-clock debug-stop strobe.
- seg_hex0  out  8  low nibble of the shown byte, segments {dp,g,f,e,d,c,b,a}, active high.
- seg_hex1  out  8  high nibble of the shown byte, same encoding.
- seg_hex2  out  8  displayed-byte count mod 16, same encoding.
- ovf  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
  - Clock port is clk, reset port is rst.
  - Reset acts only at a rising edge of clk while rst=1.
- Reset values:
  - seg_hex0/1/2 = 8'h40 (dash).
  - ovf = 0, FIFO empty, hold = 0, count = 0, state IDLE.
- Reset mid-operation discards FIFO contents and display state. Strobes in the reset cycle are ignored.
- Hex encoding, 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
- FIFO:
  - Push when tty_stb=1 and state != FROZEN.
  - Full is evaluated after the same-cycle pop: full with a simultaneous pop still accepts the push.
  - Full without a pop: byte dropped, ovf <= 1 (cleared only by rst).
  - Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
  - A pushed byte is visible as non-empty the next cycle.
- States:
  - IDLE: no byte shown yet. If the FIFO is non-empty, pop, go to SHOW.
  - SHOW: a byte is displayed.
    - On ena_ms with hold > 0, hold decrements.
    - In any cycle with hold == 0 (registered value) and the FIFO non-empty: pop.
    - If the FIFO is empty, the last byte stays displayed.
  - FROZEN: entered from any state on tty_end.
    - No pushes or pops. FIFO contents are retained but not shown.
    - hold frozen.
    - The current digits keep their value with dp forced on: seg |= 8'h80. Dashes become 8'hC0.
    - Exit only via rst.
- tty_end coinciding with a pop: FROZEN wins, no pop occurs.
- Pop action, registered:
  - hold <= HOLD_MS.
  - count <= count+1, wrapping 15 -> 0.
  - seg_hex0/1 <= encoding of the byte's nibbles.
  - seg_hex2 <= encoding of the new count.
  - Segment outputs update in the cycle after the pop.
- Latency: tty_stb in cycle 0 into an empty, idle block gives pop in cycle 1 and seg valid in cycle 2.
- Hold timing: next pop occurs in the cycle after the ena_ms that brings hold to 0; seg updates one cycle later.

Decomposition:
- Shared package qa7_seg_pkg holds:
  - SEG_HEX[0:15] encoding table.
  - SEG_DASH = 8'h40.
  - SEG_DP = 8'h80.
  - State encoding (IDLE, SHOW, FROZEN).
- One sub-module: qa7_tty_fifo.
  - Synchronous byte FIFO with push, pop, full, empty and data ports.
  - Its full flag accounts for a same-cycle pop.
- The FSM, hold counter, count and segment registers stay in qa7_tty_seg.

Test Plan:
- Reset release, no input: seg_hex0/1/2 = 40/40/40 and ovf=0 for 1000 clocks.
- tty_stb with 0x5A at cycle 0: at cycle 2, seg_hex1=6D, seg_hex0=77, seg_hex2=06.
- HOLD_MS=3, push 0x12 then 0x34 on consecutive cycles:
  - 0x12 (5B/06) holds through two ena_ms pulses.
  - After the third pulse, 0x34 (66/4F) appears 2 clocks later with seg_hex2=5B.
- DEPTH=8, HOLD_MS=250, 10 back-to-back strobes 0x00..0x09:
  - 0x00 displayed.
  - Bytes 0x01..0x08 buffered, 0x09 dropped, ovf=1.
  - After subsequent holds, last byte shown is 0x08 with seg_hex2=encoding of 9 (6F).
- Show 0xA5, then tty_end:
  - Digits become F7/ED/86.
  - A later tty_stb 0x11 and 500 ena_ms pulses leave the digits unchanged.
- Assert rst for one cycle mid-hold with 3 bytes queued:
  - Next cycle all seg outputs are 40, ovf=0.
  - No queued byte is ever displayed.
  - A new byte 0x07 shows seg_hex2=06.

Source files
------------

// File: rtl/qa7_seg_pkg.sv
// Shared definitions for the tty debug seven-segment display stage:
// segment glyphs and the display FSM state encoding.
package qa7_seg_pkg;

    localparam logic [7:0] SEG_DASH = 8'h40;
    localparam logic [7:0] SEG_DP   = 8'h80;

    // Segment order {dp,g,f,e,d,c,b,a}, active high
    localparam logic [7:0] SEG_HEX [0:15] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F,
        8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C,
        8'h39, 8'h5E, 8'h79, 8'h71
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_FROZEN
    } state_e;

    function automatic logic [7:0] seg_enc(input logic [3:0] n);
        return SEG_HEX[n];
    endfunction

endpackage

// File: rtl/qa7_tty_fifo.sv
// Small synchronous byte FIFO; full already accounts for a same-cycle pop
// so a push into a full FIFO that is being drained is still accepted.
module qa7_tty_fifo
    import qa7_seg_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign full    = (cnt == CW'(DEPTH)) && !do_pop;
    assign do_push = push && !full;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/qa7_tty_seg.sv
// Debug byte display: buffers tty bytes, shows each in hex for at least
// HOLD_MS milliseconds with a mod-16 byte count, freezes on tty_end.
module qa7_tty_seg
    import qa7_seg_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int HOLD_MS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena_ms,
    input  logic       tty_stb,
    input  logic [7:0] tty_dat,
    input  logic       tty_end,
    output logic [7:0] seg_hex0,
    output logic [7:0] seg_hex1,
    output logic [7:0] seg_hex2,
    output logic       ovf
);

    localparam int HW = (HOLD_MS > 0) ? $clog2(HOLD_MS + 1) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_MS);

    state_e        state_q;
    state_e        state_d;
    logic [HW-1:0] hold_q;
    logic [3:0]    cnt_q;
    logic [3:0]    cnt_nxt;
    logic          push;
    logic          pop;
    logic          freeze;
    logic          full;
    logic          empty;
    logic [7:0]    rd_data;

    qa7_tty_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .wr_data(tty_dat),
        .rd_data(rd_data),
        .full   (full),
        .empty  (empty)
    );

    assign push    = tty_stb && (state_q != ST_FROZEN);
    assign freeze  = (state_q != ST_FROZEN) && (state_d == ST_FROZEN);
    assign cnt_nxt = cnt_q + 4'd1;

    // tty_end has priority over a pending pop in the same cycle
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (tty_end) begin
                    state_d = ST_FROZEN;
                end else if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (tty_end) begin
                    state_d = ST_FROZEN;
                end else if (hold_q == '0 && !empty) begin
                    pop = 1'b1;
                end
            end
            ST_FROZEN: begin
                state_d = ST_FROZEN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            cnt_q    <= '0;
            seg_hex0 <= SEG_DASH;
            seg_hex1 <= SEG_DASH;
            seg_hex2 <= SEG_DASH;
            ovf      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push && full) begin
                ovf <= 1'b1;
            end
            if (pop) begin
                hold_q   <= HOLD_INIT;
                cnt_q    <= cnt_nxt;
                seg_hex0 <= seg_enc(rd_data[3:0]);
                seg_hex1 <= seg_enc(rd_data[7:4]);
                seg_hex2 <= seg_enc(cnt_nxt);
            end else if (state_q == ST_SHOW && !freeze
                         && ena_ms && hold_q != '0) begin
                hold_q <= hold_q - 1'b1;
            end
            if (freeze) begin
                seg_hex0 <= seg_hex0 | SEG_DP;
                seg_hex1 <= seg_hex1 | SEG_DP;
                seg_hex2 <= seg_hex2 | SEG_DP;
            end
        end
    end

endmodule

// File: tb/tb_qa7_tty_seg.sv
// Directed bench for qa7_tty_seg: default instance (DEPTH=8, HOLD_MS=250)
// and a short-hold instance (HOLD_MS=3) share one stimulus stream.
module tb_qa7_tty_seg;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena_ms = 1'b0;
    logic       tty_stb = 1'b0;
    logic [7:0] tty_dat = 8'h00;
    logic       tty_end = 1'b0;

    logic [7:0] h0, h1, h2;
    logic       ovf;
    logic [7:0] b0, b1, b2;
    logic       bovf;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    qa7_tty_seg dut (
        .clk     (clk),
        .rst     (rst),
        .ena_ms  (ena_ms),
        .tty_stb (tty_stb),
        .tty_dat (tty_dat),
        .tty_end (tty_end),
        .seg_hex0(h0),
        .seg_hex1(h1),
        .seg_hex2(h2),
        .ovf     (ovf)
    );

    qa7_tty_seg #(
        .DEPTH  (8),
        .HOLD_MS(3)
    ) dut3 (
        .clk     (clk),
        .rst     (rst),
        .ena_ms  (ena_ms),
        .tty_stb (tty_stb),
        .tty_dat (tty_dat),
        .tty_end (tty_end),
        .seg_hex0(b0),
        .seg_hex1(b1),
        .seg_hex2(b2),
        .ovf     (bovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse();
        ena_ms = 1'b1;
        tick();
        ena_ms = 1'b0;
        tick();
    endtask

    // {ovf, seg_hex2, seg_hex1, seg_hex0}
    function automatic logic [31:0] obs_a();
        return {7'd0, ovf, h2, h1, h0};
    endfunction

    function automatic logic [31:0] obs_b();
        return {7'd0, bovf, b2, b1, b0};
    endfunction

    initial begin
        // reset release, idle
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            chk("idle_dash", obs_a(), 32'h0_404040);
            tick();
        end

        // single byte latency
        do_reset();
        tty_dat = 8'h5A;
        tty_stb = 1'b1;
        tick();
        tty_stb = 1'b0;
        chk("lat_c1", obs_a(), 32'h0_404040);
        tick();
        chk("lat_c2", obs_a(), 32'h0_066D77);

        // hold timing, HOLD_MS=3
        do_reset();
        tty_dat = 8'h12;
        tty_stb = 1'b1;
        tick();
        tty_dat = 8'h34;
        tick();
        tty_stb = 1'b0;
        chk("hold_first", obs_b(), 32'h0_06065B);
        pulse();
        pulse();
        chk("hold_p2", obs_b(), 32'h0_06065B);
        ena_ms = 1'b1;
        tick();
        ena_ms = 1'b0;
        chk("hold_p3", obs_b(), 32'h0_06065B);
        tick();
        chk("hold_next", obs_b(), 32'h0_5B4F66);

        // overflow with DEPTH=8, HOLD_MS=250
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tty_dat = 8'(i);
            tty_stb = 1'b1;
            tick();
        end
        tty_stb = 1'b0;
        tick();
        chk("ovf_first", obs_a(), 32'h1_063F3F);
        ena_ms = 1'b1;
        repeat (260) tick();
        chk("ovf_second", obs_a(), 32'h1_5B3F06);
        repeat (1768) tick();
        ena_ms = 1'b0;
        chk("ovf_last", obs_a(), 32'h1_6F3F7F);

        // full FIFO with simultaneous pop accepts the push (HOLD_MS=3)
        do_reset();
        for (int i = 0; i < 9; i++) begin
            tty_dat = 8'(i);
            tty_stb = 1'b1;
            tick();
        end
        tty_stb = 1'b0;
        tick();
        chk("fullpop_first", obs_b(), 32'h0_063F3F);
        pulse();
        pulse();
        ena_ms = 1'b1;
        tick();
        ena_ms = 1'b0;
        tty_dat = 8'h99;
        tty_stb = 1'b1;
        tick();
        tty_stb = 1'b0;
        tick();
        chk("fullpop_noovf", obs_b(), 32'h0_5B3F06);
        repeat (40) pulse();
        chk("fullpop_last", obs_b(), 32'h0_776F6F);

        // freeze on a shown byte
        do_reset();
        tty_dat = 8'hA5;
        tty_stb = 1'b1;
        tick();
        tty_stb = 1'b0;
        tick();
        chk("frz_show", obs_a(), 32'h0_06776D);
        tty_end = 1'b1;
        tick();
        tty_end = 1'b0;
        chk("frz_dp", obs_a(), 32'h0_86F7ED);
        tty_dat = 8'h11;
        tty_stb = 1'b1;
        tick();
        tty_stb = 1'b0;
        ena_ms = 1'b1;
        repeat (500) tick();
        ena_ms = 1'b0;
        chk("frz_hold", obs_a(), 32'h0_86F7ED);

        // freeze before anything shown
        do_reset();
        tty_end = 1'b1;
        tick();
        tty_end = 1'b0;
        chk("frz_dash", obs_a(), 32'h0_C0C0C0);
        tty_dat = 8'h22;
        tty_stb = 1'b1;
        tick();
        tty_stb = 1'b0;
        tick();
        tick();
        chk("frz_dash_hold", obs_a(), 32'h0_C0C0C0);

        // tty_end wins over a same-cycle pop
        do_reset();
        tty_dat = 8'h33;
        tty_stb = 1'b1;
        tick();
        tty_stb = 1'b0;
        tty_end = 1'b1;
        tick();
        tty_end = 1'b0;
        tick();
        chk("end_vs_pop", obs_a(), 32'h0_C0C0C0);

        // reset mid-hold with queued bytes
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            tty_dat = 8'(i);
            tty_stb = 1'b1;
            tick();
        end
        tty_stb = 1'b0;
        tick();
        chk("mid_show", obs_a(), 32'h0_063F06);
        pulse();
        rst = 1'b1;
        tty_dat = 8'hEE;
        tty_stb = 1'b1;
        tick();
        rst = 1'b0;
        tty_stb = 1'b0;
        chk("mid_rst", obs_a(), 32'h0_404040);
        ena_ms = 1'b1;
        for (int i = 0; i < 6; i++) begin
            repeat (100) tick();
            chk("mid_empty", obs_a(), 32'h0_404040);
        end
        ena_ms = 1'b0;
        tty_dat = 8'h07;
        tty_stb = 1'b1;
        tick();
        tty_stb = 1'b0;
        tick();
        chk("mid_new", obs_a(), 32'h0_063F07);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
